id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register. It sits directly downstream of the GPR register file and consumes its combinational read data (rs1d/rs2d).
- Captures the operands, immediate, opcode and destination for the execute stage.
- Bypasses the same-cycle GPR writeback, because the GPR write is registered while its read is combinational.
- Detects load-use hazards and inserts bubbles. Supports valid/ready handshaking, flush and a bubble counter.

---
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with same-cycle writeback bypass,
// load-use bubble insertion, valid/ready handshake, flush and bubble counter.
module id_ex_stage #(
    parameter int WordSize = 32,
    parameter int OpWidth  = 6,
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [4:0]          id_rs1n,
    input  logic [4:0]          id_rs2n,
    input  logic [4:0]          id_rdn,
    input  logic [WordSize-1:0] id_rs1d,
    input  logic [WordSize-1:0] id_rs2d,
    input  logic [WordSize-1:0] id_imm,
    input  logic [OpWidth-1:0]  id_op,
    input  logic                id_wbe,
    input  logic                id_is_load,
    input  logic                wb_wbe,
    input  logic [4:0]          wb_rdn,
    input  logic [WordSize-1:0] wb_rdd,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [WordSize-1:0] ex_rs1d,
    output logic [WordSize-1:0] ex_rs2d,
    output logic [WordSize-1:0] ex_imm,
    output logic [OpWidth-1:0]  ex_op,
    output logic [4:0]          ex_rdn,
    output logic                ex_wbe,
    output logic                ex_is_load,
    output logic [CntWidth-1:0] bubble_cnt
);

    typedef struct packed {
        logic [WordSize-1:0] rs1d;
        logic [WordSize-1:0] rs2d;
        logic [WordSize-1:0] imm;
        logic [OpWidth-1:0]  op;
        logic [4:0]          rdn;
        logic                wbe;
        logic                is_load;
    } ex_pl_t;

    ex_pl_t              pl_q, pl_d;
    logic                vld_q;
    logic [CntWidth-1:0] cnt_q;
    logic                hazard, slot_free, accept, bub_inc;

    // GPR write lands on the next edge, so a same-cycle write must be forwarded here
    function automatic logic [WordSize-1:0] byp(input logic [4:0] n,
                                                input logic [WordSize-1:0] d);
        return (n != 5'd0 && wb_wbe && wb_rdn == n) ? wb_rdd : d;
    endfunction

    assign hazard = vld_q & pl_q.is_load & pl_q.wbe & (pl_q.rdn != 5'd0) &
                    ((pl_q.rdn == id_rs1n) | (pl_q.rdn == id_rs2n));
    assign slot_free = ~vld_q | ex_ready;
    assign id_ready  = slot_free & ~hazard & ~flush;
    assign accept    = id_valid & id_ready;
    assign bub_inc   = id_valid & hazard & ex_ready & ~flush;

    always_comb begin
        pl_d.rs1d    = byp(id_rs1n, id_rs1d);
        pl_d.rs2d    = byp(id_rs2n, id_rs2d);
        pl_d.imm     = id_imm;
        pl_d.op      = id_op;
        pl_d.rdn     = id_rdn;
        pl_d.wbe     = id_wbe;
        pl_d.is_load = id_is_load;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= 1'b0;
            pl_q  <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q <= 1'b1;
            pl_q  <= pl_d;
        end else if (slot_free) begin
            vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                      cnt_q <= '0;
        else if (bub_inc && ~&cnt_q)    cnt_q <= cnt_q + 1'b1;
    end

    assign ex_valid   = vld_q;
    assign ex_rs1d    = pl_q.rs1d;
    assign ex_rs2d    = pl_q.rs2d;
    assign ex_imm     = pl_q.imm;
    assign ex_op      = pl_q.op;
    assign ex_rdn     = pl_q.rdn;
    assign ex_wbe     = pl_q.wbe;
    assign ex_is_load = pl_q.is_load;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a transaction-level slot model.
module tb_id_ex_stage;
    localparam int W  = 32;
    localparam int OW = 6;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          id_valid, id_ready;
    logic [4:0]    id_rs1n, id_rs2n, id_rdn;
    logic [W-1:0]  id_rs1d, id_rs2d, id_imm;
    logic [OW-1:0] id_op;
    logic          id_wbe, id_is_load;
    logic          wb_wbe;
    logic [4:0]    wb_rdn;
    logic [W-1:0]  wb_rdd;
    logic          flush, ex_ready;
    logic          ex_valid;
    logic [W-1:0]  ex_rs1d, ex_rs2d, ex_imm;
    logic [OW-1:0] ex_op;
    logic [4:0]    ex_rdn;
    logic          ex_wbe, ex_is_load;
    logic [CW-1:0] bubble_cnt;

    id_ex_stage #(.WordSize(W), .OpWidth(OW), .CntWidth(CW)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1n(id_rs1n), .id_rs2n(id_rs2n), .id_rdn(id_rdn),
        .id_rs1d(id_rs1d), .id_rs2d(id_rs2d), .id_imm(id_imm),
        .id_op(id_op), .id_wbe(id_wbe), .id_is_load(id_is_load),
        .wb_wbe(wb_wbe), .wb_rdn(wb_rdn), .wb_rdd(wb_rdd),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_rs1d(ex_rs1d), .ex_rs2d(ex_rs2d),
        .ex_imm(ex_imm), .ex_op(ex_op), .ex_rdn(ex_rdn),
        .ex_wbe(ex_wbe), .ex_is_load(ex_is_load), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  rs1d, rs2d, imm;
        logic [OW-1:0] op;
        logic [4:0]    rdn;
        logic          wbe, is_load;
    } ins_t;

    ins_t m_ins;
    bit   m_valid;
    int   m_cnt;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_valid = 0;
        m_cnt   = 0;
        m_ins   = '{rs1d: '0, rs2d: '0, imm: '0, op: '0, rdn: '0, wbe: 1'b0, is_load: 1'b0};
    endtask

    function automatic logic [W-1:0] operand(input logic [4:0] n, input logic [W-1:0] gpr);
        if (n != 0 && wb_wbe && wb_rdn == n) return wb_rdd;
        return gpr;
    endfunction

    task automatic chk_outputs();
        chk("ex_valid",   64'(ex_valid),   64'(m_valid));
        chk("ex_rs1d",    64'(ex_rs1d),    64'(m_ins.rs1d));
        chk("ex_rs2d",    64'(ex_rs2d),    64'(m_ins.rs2d));
        chk("ex_imm",     64'(ex_imm),     64'(m_ins.imm));
        chk("ex_op",      64'(ex_op),      64'(m_ins.op));
        chk("ex_rdn",     64'(ex_rdn),     64'(m_ins.rdn));
        chk("ex_wbe",     64'(ex_wbe),     64'(m_ins.wbe));
        chk("ex_is_load", 64'(ex_is_load), 64'(m_ins.is_load));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    endtask

    // One cycle: check id_ready for the current inputs, advance the model, check the result
    task automatic step();
        bit load_use, room, take;
        #1;
        load_use = m_valid && m_ins.is_load && m_ins.wbe && m_ins.rdn != 0 &&
                   (m_ins.rdn == id_rs1n || m_ins.rdn == id_rs2n);
        room = !m_valid || ex_ready;
        take = id_valid && room && !load_use && !flush;
        chk("id_ready", 64'(id_ready), 64'(room && !load_use && !flush));
        if (id_valid && load_use && ex_ready && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
        if (flush) m_valid = 0;
        else if (take) begin
            m_valid = 1;
            m_ins = '{rs1d: operand(id_rs1n, id_rs1d), rs2d: operand(id_rs2n, id_rs2d),
                      imm: id_imm, op: id_op, rdn: id_rdn, wbe: id_wbe, is_load: id_is_load};
        end else if (room) m_valid = 0;
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [W-1:0] d1,
                          input logic [4:0] r2, input logic [W-1:0] d2, input logic [4:0] rd,
                          input logic [W-1:0] imm, input logic wbe, input logic ld);
        id_valid = v; id_rs1n = r1; id_rs1d = d1; id_rs2n = r2; id_rs2d = d2;
        id_rdn = rd; id_imm = imm; id_wbe = wbe; id_is_load = ld;
        id_op = OW'(imm);
    endtask

    initial begin
        rstn = 1'b0; flush = 0; ex_ready = 0; wb_wbe = 0; wb_rdn = 0; wb_rdd = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #12;
        chk_outputs();
        chk("id_ready_rst", 64'(id_ready), 64'(1));
        @(negedge clk);
        rstn = 1'b1;

        // simple transfer
        ex_ready = 1;
        set_id(1, 3, 'h11, 4, 'h22, 1, 'h5, 1, 0);
        step();
        chk("t1_rs1d", 64'(ex_rs1d), 64'h11);
        chk("t1_rs2d", 64'(ex_rs2d), 64'h22);
        chk("t1_imm",  64'(ex_imm),  64'h5);
        chk("t1_vld",  64'(ex_valid), 64'h1);

        // bypass, then x0 never bypassed
        set_id(1, 7, 'hAAAA, 2, 'h3, 2, 'h6, 1, 0);
        wb_wbe = 1; wb_rdn = 7; wb_rdd = 'h1234;
        step();
        chk("t2_byp", 64'(ex_rs1d), 64'h1234);
        set_id(1, 0, 0, 2, 'h3, 2, 'h6, 1, 0);
        wb_rdn = 0; wb_rdd = 'hFFFF;
        step();
        chk("t2_x0", 64'(ex_rs1d), 64'h0);
        wb_wbe = 0;

        // load-use: one bubble then capture
        set_id(1, 1, 'h9, 2, 'h8, 5, 'h0, 1, 1);
        step();
        set_id(1, 1, 'h9, 5, 'h77, 6, 'h1, 1, 0);
        step();
        chk("t3_bubble", 64'(ex_valid), 64'h0);
        chk("t3_cnt", 64'(bubble_cnt), 64'h1);
        step();
        chk("t3_capt", 64'(ex_rs2d), 64'h77);

        // execute stall for 3 cycles, then release
        ex_ready = 0;
        set_id(1, 2, 'h42, 3, 'h43, 4, 'h2, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold", 64'(ex_rs2d), 64'h77);
        end
        ex_ready = 1;
        step();
        chk("t4_capt", 64'(ex_rs1d), 64'h42);

        // flush kills incoming instruction
        flush = 1;
        set_id(1, 2, 'h99, 3, 'h98, 4, 'h3, 1, 0);
        step();
        chk("t5_flush", 64'(ex_valid), 64'h0);
        chk("t5_nocap", 64'(ex_rs1d), 64'h42);
        flush = 0;

        // randomized traffic with small register indices to provoke hazards and bypass
        for (int c = 0; c < 3000; c++) begin
            set_id(1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)));
            id_op    = OW'($urandom);
            wb_wbe   = 1'($urandom_range(0, 1));
            wb_rdn   = 5'($urandom_range(0, 7));
            wb_rdd   = $urandom;
            flush    = 1'($urandom_range(0, 9) == 0);
            ex_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end

        // get a valid entry, stall it, and reset asynchronously mid-stall
        flush = 0; ex_ready = 1;
        set_id(1, 0, 'h5, 0, 'h6, 3, 'h7, 1, 1);
        step();
        step();
        ex_ready = 0;
        step();
        chk("t6_vld_pre", 64'(ex_valid), 64'h1);
        #2;
        rstn = 1'b0;
        m_reset();
        #1;
        chk_outputs();
        chk("t6_ready_rst", 64'(id_ready), 64'(1));
        @(negedge clk);
        rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
